// File: rtl/timestamp_tx_pkg.sv
// Shared types, ASCII constants and the hex digit encoder for the timestamp transmitter.
package timestamp_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      GAP
   } state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

   // Uppercase hex digit: 0..9 -> '0'..'9', 10..15 -> 'A'..'F'.
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] v);
      if (v < 4'd10) begin
         return ASCII_0 + {4'h0, v};
      end
      return ASCII_A + {4'h0, v} - 8'd10;
   endfunction

endpackage

// File: rtl/timestamp_uart_byte_tx.sv
// One 8N1 character: baud prescaler plus start/data/stop shifting.
// A load accepted on the final stop-bit cycle chains the next character with no idle cycle.
module timestamp_uart_byte_tx
   import timestamp_tx_pkg::*;
#(
   parameter int unsigned C_DIV = 2500
) (
   input  logic       ck_i,
   input  logic       xarst_i,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   output logic       txd_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       stop_last_nxt_o
);

   localparam int unsigned   CW       = (C_DIV > 1) ? $clog2(C_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(C_DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          txd_q, txd_d;
   logic          tick;

   assign tick            = (cnt_q == CNT_LAST);
   assign txd_o           = txd_q;
   assign busy_o          = (state_q != IDLE);
   assign done_o          = (state_q == STOP) && tick;
   // Lets the parent register DONE so it lands on the final stop-bit cycle.
   assign stop_last_nxt_o = (state_d == STOP) && (cnt_d == CNT_LAST);

   // Next-state: bit sequencing on prescaler ticks.
   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      txd_d   = txd_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            txd_d = 1'b1;
            if (load_i) begin
               state_d = START;
               sh_d    = byte_i;
               txd_d   = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
               txd_d   = sh_q[0];
               sh_d    = {1'b0, sh_q[7:1]};
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
                  txd_d = sh_q[0];
                  sh_d  = {1'b0, sh_q[7:1]};
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (load_i) begin
                  state_d = START;
                  sh_d    = byte_i;
                  txd_d   = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            txd_d   = 1'b1;
         end
      endcase
   end

   // State register; line idles high.
   always_ff @(posedge ck_i or negedge xarst_i) begin
      if (!xarst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: rtl/timestamp_uart_tx.sv
// Timestamp transmitter: latches TS_i, sends it as uppercase hex ASCII (MSB digit first)
// plus a terminator over UART 8N1, then an idle gap.
// Build option: TIMESTAMP_TX_CRLF_EN selects a CR LF terminator instead of a single space.
// Frame-level states: START covers the whole run of characters (the byte engine refines
// it into START/DATA/STOP); GAP is the trailing mark time.
module timestamp_uart_tx
   import timestamp_tx_pkg::*;
#(
   parameter int unsigned C_FCK       = 48_000_000,
   parameter int unsigned C_BAUD_RATE = 19_200,
   parameter int unsigned C_TS_W      = 32,
   parameter int unsigned C_REPEAT    = 1,
   parameter int unsigned C_GAP_BITS  = 10
) (
   input  logic              CK_i,
   input  logic              XARST_i,
   input  logic [C_TS_W-1:0] TS_i,
   input  logic              START_i,
   output logic              TXD_o,
   output logic              BUSY_o,
   output logic              DONE_o
);

   localparam int unsigned C_DIV   = (C_FCK + C_BAUD_RATE / 2) / C_BAUD_RATE;
   localparam int unsigned ND      = C_TS_W / 4;
`ifdef TIMESTAMP_TX_CRLF_EN
   localparam int unsigned NT      = 2;
`else
   localparam int unsigned NT      = 1;
`endif
   localparam int unsigned NC      = ND + NT;
   localparam int unsigned IW      = $clog2(NC);
   localparam int unsigned GAP_CYC = C_GAP_BITS * C_DIV;
   localparam int unsigned GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(NC - 1);
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [C_TS_W-1:0] shadow_q, shadow_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              go;
   logic              bt_load;
   logic [7:0]        bt_byte;
   logic              bt_txd, bt_busy, bt_done, bt_last_nxt;

   // Character idx of the frame built from timestamp ts.
   function automatic logic [7:0] char_at(input logic [C_TS_W-1:0] ts, input logic [IW-1:0] idx);
      logic [C_TS_W-1:0] sh;
      if (32'(idx) < ND) begin
         sh = ts >> (4 * (ND - 1 - 32'(idx)));
         return hex_to_ascii(sh[3:0]);
      end
`ifdef TIMESTAMP_TX_CRLF_EN
      return (32'(idx) == ND) ? ASCII_CR : ASCII_LF;
`else
      return ASCII_SP;
`endif
   endfunction

   assign go = (C_REPEAT != 0) || START_i;

   // Frame sequencing: latch, feed characters back to back, gap, registered flags.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      gap_d    = gap_q;
      bt_load  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go && !bt_busy) begin
               shadow_d = TS_i;
               idx_d    = '0;
               bt_load  = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            if (bt_done) begin
               if (idx_q != IDX_LAST) begin
                  idx_d   = idx_q + 1'b1;
                  bt_load = 1'b1;
               end else if (GAP_CYC == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  gap_d   = '0;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Byte mux runs off next-state values so the first digit comes straight from TS_i.
      bt_byte = char_at(shadow_d, idx_d);
      busy_d  = (state_d != IDLE);
      if (GAP_CYC == 0) begin
         done_d = (state_q == START) && bt_last_nxt && (idx_q == IDX_LAST);
      end else begin
         done_d = (state_d == GAP) && (gap_d == GAP_LAST);
      end
   end

   // Frame state register.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         gap_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         gap_q    <= gap_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   timestamp_uart_byte_tx #(
      .C_DIV (C_DIV)
   ) u_byte_tx (
      .ck_i            (CK_i),
      .xarst_i         (XARST_i),
      .load_i          (bt_load),
      .byte_i          (bt_byte),
      .txd_o           (bt_txd),
      .busy_o          (bt_busy),
      .done_o          (bt_done),
      .stop_last_nxt_o (bt_last_nxt)
   );

   assign TXD_o  = bt_txd;
   assign BUSY_o = busy_q;
   assign DONE_o = done_q;

endmodule

// File: tb/tb_timestamp_uart_tx.sv
// Bench for timestamp_uart_tx: three instances (32-bit one-shot, 16-bit one-shot,
// 8-bit free-running with no gap); UART decoders check bytes against expected queues.
module tb_timestamp_uart_tx;

   localparam int DIV = 16;
`ifdef TIMESTAMP_TX_CRLF_EN
   localparam int TERM_N = 2;
`else
   localparam int TERM_N = 1;
`endif
   localparam int NC0 = 8 + TERM_N;
   localparam int NC1 = 4 + TERM_N;
   localparam int NC2 = 2 + TERM_N;
   localparam int L0  = (NC0 * 10 + 10) * DIV;
   localparam int L1  = (NC1 * 10 + 10) * DIV;
   localparam int L2  = (NC2 * 10) * DIV;

   logic        clk = 1'b0;
   logic        rst_n, rst0_n;
   logic [31:0] ts0;
   logic [15:0] ts1;
   logic [7:0]  ts2;
   logic        st0, st1, st2;
   logic        txd0, txd1, txd2, busy0, busy1, busy2, done0, done1, done2;

   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   bit          mon_en [3];
   logic [7:0]  q0[$], q1[$], q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timestamp_uart_tx #(.C_FCK(16), .C_BAUD_RATE(1), .C_TS_W(32), .C_REPEAT(0), .C_GAP_BITS(10)) dut0 (
      .CK_i(clk), .XARST_i(rst0_n), .TS_i(ts0), .START_i(st0), .TXD_o(txd0), .BUSY_o(busy0), .DONE_o(done0));
   timestamp_uart_tx #(.C_FCK(16), .C_BAUD_RATE(1), .C_TS_W(16), .C_REPEAT(0), .C_GAP_BITS(10)) dut1 (
      .CK_i(clk), .XARST_i(rst_n), .TS_i(ts1), .START_i(st1), .TXD_o(txd1), .BUSY_o(busy1), .DONE_o(done1));
   timestamp_uart_tx #(.C_FCK(16), .C_BAUD_RATE(1), .C_TS_W(8), .C_REPEAT(1), .C_GAP_BITS(0)) dut2 (
      .CK_i(clk), .XARST_i(rst_n), .TS_i(ts2), .START_i(st2), .TXD_o(txd2), .BUSY_o(busy2), .DONE_o(done2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic txd_of(input int k);
      case (k) 0: return txd0; 1: return txd1; default: return txd2; endcase
   endfunction
   function automatic logic busy_of(input int k);
      case (k) 0: return busy0; 1: return busy1; default: return busy2; endcase
   endfunction
   function automatic logic done_of(input int k);
      case (k) 0: return done0; 1: return done1; default: return done2; endcase
   endfunction

   function automatic logic [7:0] exp_hex(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h37 + 8'(v));
   endfunction

   task automatic push_byte(input int k, input logic [7:0] b);
      case (k) 0: q0.push_back(b); 1: q1.push_back(b); default: q2.push_back(b); endcase
   endtask

   task automatic push_frame(input int k, input logic [63:0] ts, input int nd);
      logic [63:0] t;
      for (int i = nd - 1; i >= 0; i--) begin
         t = ts >> (4 * i);
         push_byte(k, exp_hex(t[3:0]));
      end
`ifdef TIMESTAMP_TX_CRLF_EN
      push_byte(k, 8'h0D);
      push_byte(k, 8'h0A);
`else
      push_byte(k, 8'h20);
`endif
   endtask

   // UART receiver: samples mid-bit on falling clock edges and scores each byte.
   task automatic monitor(input int k);
      logic [7:0] b, e;
      logic       stp, have;
      forever begin
         @(negedge clk);
         if (mon_en[k] && txd_of(k) === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = txd_of(k);
            end
            repeat (DIV) @(negedge clk);
            stp = txd_of(k);
            if (mon_en[k]) begin
               if (k == 2 && q2.size() == 0) push_frame(2, 64'(ts2), 2);
               have = 1'b0;
               e    = '0;
               case (k)
                  0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
                  1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
                  default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
               endcase
               check($sformatf("rx%0d_byte_expected", k), have, 1'b1);
               if (have) check($sformatf("rx%0d_byte", k), b, e);
               check($sformatf("rx%0d_stop", k), stp, 1'b1);
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);

   // Free-running instance must ignore its START input entirely.
   initial begin
      st2 = 1'b0;
      forever begin
         @(negedge clk);
         st2 = 1'($urandom_range(0, 1));
      end
   end

   // Waits from the current falling edge until DONE, counting BUSY cycles on the way.
   task automatic wait_done(input int k, input int lim, output int dc, output int bc);
      bc = 0;
      dc = -1;
      for (int i = 0; i < lim; i++) begin
         if (busy_of(k)) bc++;
         if (done_of(k)) begin
            dc = cyc;
            break;
         end
         @(negedge clk);
      end
      check($sformatf("done%0d_seen", k), (dc >= 0), 1'b1);
   endtask

   initial begin
      int s, d, bc, d2;
      bit stuck;
      rst_n = 1'b0; rst0_n = 1'b0;
      st0 = 1'b0; st1 = 1'b0;
      ts0 = 32'h1234ABCD; ts1 = 16'h00F9; ts2 = 8'h5C;
      mon_en[0] = 1'b1; mon_en[1] = 1'b1; mon_en[2] = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_txd0", txd0, 1'b1);
      check("rst_busy0", busy0, 1'b0);
      check("rst_done0", done0, 1'b0);
      check("rst_txd2", txd2, 1'b1);
      check("rst_busy2", busy2, 1'b0);

      // Free-running: first frame starts on the first clock after release.
      push_frame(2, 64'(ts2), 2);
      rst_n = 1'b1; rst0_n = 1'b1;
      @(negedge clk);
      check("rep_first_start_txd", txd2, 1'b0);
      check("rep_first_start_busy", busy2, 1'b1);
      s = cyc;
      wait_done(2, L2 + 20, d, bc);
      check("rep_frame_len", d - s, L2 - 1);
      @(negedge clk);
      check("rep_idle_txd", txd2, 1'b1);
      check("rep_idle_busy", busy2, 1'b0);
      check("rep_done_width", done2, 1'b0);
      @(negedge clk);
      check("rep_next_start_txd", txd2, 1'b0);
      check("rep_next_start_busy", busy2, 1'b1);
      s = cyc;
      wait_done(2, L2 + 20, d2, bc);
      check("rep_frame2_len", d2 - s, L2 - 1);

      // One-shot 32-bit frame; TS changes during 2nd char and START pulses mid-frame.
      push_frame(0, 64'h1234ABCD, 8);
      st0 = 1'b1;
      @(negedge clk);
      st0 = 1'b0;
      check("f0_start_txd", txd0, 1'b0);
      check("f0_start_busy", busy0, 1'b1);
      s = cyc;
      repeat (200) @(negedge clk);
      ts0 = 32'hFFFFFFFF;
      repeat (300) @(negedge clk);
      st0 = 1'b1;
      @(negedge clk);
      st0 = 1'b0;
      wait_done(0, L0, d, bc);
      check("f0_done_cycle", d - s, L0 - 1);
      @(negedge clk);
      check("f0_done_width", done0, 1'b0);
      check("f0_busy_end", busy0, 1'b0);
      stuck = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (busy0 !== 1'b0 || txd0 !== 1'b1) stuck = 1'b1;
      end
      check("f0_no_extra_frame", stuck, 1'b0);
      check("f0_bytes_all_seen", q0.size(), 0);

      // Next frame carries the updated timestamp.
      push_frame(0, 64'hFFFFFFFF, 8);
      st0 = 1'b1;
      @(negedge clk);
      st0 = 1'b0;
      wait_done(0, L0 + 20, d, bc);
      check("f0b_busy_cycles", bc, L0);
      repeat (20) @(negedge clk);
      check("f0b_bytes_all_seen", q0.size(), 0);

      // 16-bit one-shot frame: BUSY length.
      push_frame(1, 64'h00F9, 4);
      st1 = 1'b1;
      @(negedge clk);
      st1 = 1'b0;
      s = cyc;
      wait_done(1, L1 + 20, d, bc);
      check("f1_busy_cycles", bc, L1);
      check("f1_done_cycle", d - s, L1 - 1);
      repeat (20) @(negedge clk);
      check("f1_bytes_all_seen", q1.size(), 0);

      // START held high: back-to-back frames with one IDLE cycle between.
      push_frame(1, 64'h00F9, 4);
      push_frame(1, 64'h00F9, 4);
      st1 = 1'b1;
      @(negedge clk);
      wait_done(1, L1 + 20, d, bc);
      @(negedge clk);
      check("held_idle_busy", busy1, 1'b0);
      check("held_idle_txd", txd1, 1'b1);
      @(negedge clk);
      check("held_restart_txd", txd1, 1'b0);
      check("held_restart_busy", busy1, 1'b1);
      repeat (100) @(negedge clk);
      st1 = 1'b0;
      wait_done(1, L1, d, bc);
      stuck = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (busy1 !== 1'b0) stuck = 1'b1;
      end
      check("held_stops_after_release", stuck, 1'b0);
      check("held_bytes_all_seen", q1.size(), 0);

      // Asynchronous reset in the middle of data bit 3 of the first character.
      mon_en[0] = 1'b0;
      st0 = 1'b1;
      @(negedge clk);
      st0 = 1'b0;
      s = cyc;
      repeat (70) @(negedge clk);
      check("pre_rst_txd_bit3", txd0, 1'b0);
      rst0_n = 1'b0;
      #1;
      check("async_rst_txd", txd0, 1'b1);
      check("async_rst_busy", busy0, 1'b0);
      check("async_rst_done", done0, 1'b0);
      @(negedge clk);
      rst0_n = 1'b1;
      stuck = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (txd0 !== 1'b1 || busy0 !== 1'b0) stuck = 1'b1;
      end
      check("post_rst_quiet", stuck, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
